// File: rtl/cpu_pkg.sv
// Shared types and defaults for the bus arbiter: FSM state encoding,
// default requester count / hold limit, and the owner index width.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 8;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W = owner_width(DEF_NREQ);

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: scans req from ptr upward with wrap and
// returns the first requester that is high.
module rr_pick
  import cpu_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = owner_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic [W-1:0]    idx,
  output logic            any
);

  always_comb begin
    logic [W:0] pos;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ, so one conditional subtract is enough for the wrap
      pos = {1'b0, ptr} + (W+1)'(i);
      if (pos >= (W+1)'(NREQ)) pos = pos - (W+1)'(NREQ);
      if (!any && req[pos[W-1:0]]) begin
        any = 1'b1;
        idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Tri-state bus arbiter: round-robin grants with one dead TURN cycle per owner change.
// Define BUS_ARBITER_TIMEOUT_EN to add the hold counter, preemption and lock.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter  int NREQ     = DEF_NREQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int W        = owner_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [W-1:0]    owner,
  output logic            bus_idle,
  output state_t          state,
  output logic [W-1:0]    ptr
);

  logic            armed;
  logic [W-1:0]    pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] pick_onehot;
  logic            owner_req;
  logic            others;
  logic [W-1:0]    next_ptr;
  logic            start;
  logic            preempt;

  rr_pick #(.NREQ(NREQ), .W(W)) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_req   = req[owner];
  assign others      = |(req & ~grant);
  assign next_ptr    = (owner == W'(NREQ-1)) ? '0 : owner + W'(1);
  // armed holds off the first grant until one full edge after reset release
  assign start       = pick_any && ((state == IDLE && armed) || state == TURN);

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign preempt = (hold_cnt == 8'(MAX_HOLD-1)) && others && !lock[owner];
`else
  logic unused_cfg;
  assign preempt    = 1'b0;
  assign unused_cfg = ^{lock, 8'(MAX_HOLD), others};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      bus_idle    <= 1'b1;
      ptr         <= '0;
      armed       <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE, TURN: begin
          if (start) begin
            state       <= GRANT;
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            owner       <= pick_idx;
            bus_idle    <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // release and preemption share one exit, so ptr advances once
          if (!owner_req || preempt) begin
            state       <= TURN;
            grant       <= '0;
            grant_valid <= 1'b0;
            owner       <= '0;
            bus_idle    <= 1'b1;
            ptr         <= next_ptr;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (hold_cnt != 8'(MAX_HOLD-1)) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (NREQ=4, MAX_HOLD=8); expectations
// follow BUS_ARBITER_TIMEOUT_EN where timeout behaviour differs.
module tb_bus_arbiter;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] owner;
  logic       bus_idle;
  state_t     state;
  logic [1:0] ptr;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          vectors;
  int          miscompares;
  logic [3:0]  prev_grant;

  bus_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner),
    .bus_idle    (bus_idle),
    .state       (state),
    .ptr         (ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view: {grant, grant_valid, owner, bus_idle, state, ptr}
  function automatic logic [11:0] pack_exp(input logic [3:0] g, input logic [1:0] o,
                                           input state_t st, input logic [1:0] p);
    return {g, |g, o, st != GRANT, 2'(st), p};
  endfunction

  function automatic logic [11:0] pack_out();
    return {grant, grant_valid, owner, bus_idle, 2'(state), ptr};
  endfunction

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got g=%b gv=%b o=%0d idle=%b st=%0d p=%0d, expected g=%b gv=%b o=%0d idle=%b st=%0d p=%0d",
               nm, act[11:8], act[7], act[6:5], act[4], act[3:2], act[1:0],
               exp[11:8], exp[7], exp[6:5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  // driver: apply inputs for one edge and queue the state expected after it
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                     input logic [1:0] o, input state_t st, input logic [1:0] p,
                     input string nm);
    @(negedge clk);
    req  = r;
    lock = l;
    exp_q.push_back(pack_exp(g, o, st, p));
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_async", pack_out(), pack_exp(4'b0000, 2'd0, IDLE, 2'd0));
    @(negedge clk);
    rst  = 1'b1;
    req  = r;
    lock = 4'b0000;
    exp_q.push_back(pack_exp(4'b0000, 2'd0, IDLE, 2'd0));
    name_q.push_back("armed_edge");
    @(posedge clk);
  endtask

  // monitor: scoreboard compare plus grant-protocol checks every cycle
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(name_q.pop_front(), pack_out(), exp_q.pop_front());
    if (rst) begin
      vectors++;
      if (!$onehot0(grant)) begin
        miscompares++;
        $display("FAIL grant_onehot0: got %b, required at most one bit set", grant);
      end
      vectors++;
      if (prev_grant != 4'b0 && grant != 4'b0 && grant != prev_grant) begin
        miscompares++;
        $display("FAIL grant_switch: got %b after %b, required a zero cycle between owners",
                 grant, prev_grant);
      end
    end
    prev_grant = grant;
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_grant  = 4'b0;
    rst  = 1'b0;
    req  = 4'b0000;
    lock = 4'b0000;

    // single requester: grant, release through TURN to IDLE
    do_reset(4'b0000);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, GRANT, 2'd0, "single_grant");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, TURN,  2'd1, "single_turn");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, IDLE,  2'd1, "single_idle");

    // all requesting
    do_reset(4'b0000);
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++)
        cyc(4'b1111, 4'b0000, 4'(1 << k), 2'(k), GRANT, 2'(k), "rr_hold");
      cyc(4'b1111, 4'b0000, 4'b0000, 2'd0, TURN, 2'((k + 1) % 4), "rr_turn");
    end
    cyc(4'b1111, 4'b0000, 4'b0001, 2'd0, GRANT, 2'd0, "rr_wrap");
`else
    for (int c = 0; c < 20; c++)
      cyc(4'b1111, 4'b0000, 4'b0001, 2'd0, GRANT, 2'd0, "no_timeout_hold");
`endif
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, TURN, 2'd1, "rr_release");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, IDLE, 2'd1, "rr_idle");

    // lock on owner 0 blocks preemption
    do_reset(4'b0000);
    cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, GRANT, 2'd0, "lock_grant");
    for (int c = 0; c < 20; c++)
      cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, GRANT, 2'd0, "lock_hold");
`ifdef BUS_ARBITER_TIMEOUT_EN
    cyc(4'b0011, 4'b0000, 4'b0000, 2'd0, TURN,  2'd1, "lock_clear_turn");
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, GRANT, 2'd1, "lock_next");
`else
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, GRANT, 2'd0, "lock_ignored");
    cyc(4'b0010, 4'b0000, 4'b0000, 2'd0, TURN,  2'd1, "release_turn");
    cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, GRANT, 2'd1, "lock_next");
`endif
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, TURN, 2'd2, "lock_release");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, IDLE, 2'd2, "lock_idle");

    // owner 2 releases in the cycle its hold count hits the limit
    for (int c = 0; c < 8; c++)
      cyc(4'b0110, 4'b0000, 4'b0100, 2'd2, GRANT, 2'd2, "hold_to_limit");
    cyc(4'b0010, 4'b0000, 4'b0000, 2'd0, TURN,  2'd3, "release_at_limit");
    cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, GRANT, 2'd3, "grant_after_limit");
    for (int c = 0; c < 10; c++)
      cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, GRANT, 2'd3, "sole_owner");

    // reset in the middle of a grant to requester 2
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, TURN,  2'd2, "turn_before_reset");
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, GRANT, 2'd2, "grant_c2");
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, GRANT, 2'd2, "grant_c2_hold");
    do_reset(4'b0100);
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, GRANT, 2'd0, "grant_second_edge");

    // pointer wrap 3 -> 0
    cyc(4'b1001, 4'b0000, 4'b0000, 2'd0, TURN,  2'd3, "wrap_turn3");
    cyc(4'b1001, 4'b0000, 4'b1000, 2'd3, GRANT, 2'd3, "wrap_grant3");
    cyc(4'b0001, 4'b0000, 4'b0000, 2'd0, TURN,  2'd0, "wrap_turn0");
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, GRANT, 2'd0, "wrap_grant0");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, TURN,  2'd1, "final_turn");
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, IDLE,  2'd1, "final_idle");

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
